// File: rtl/stack_pointer_if.sv
// Request/response bundle between the CPU datapath and the stack pointer unit.
interface stack_pointer_if;
   logic        push;
   logic        pop;
   logic        load;
   logic [15:0] load_val;
   logic        clear_err;
   logic [15:0] sp;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic        mem_re;
   logic [15:0] depth;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        underflow;

   modport master (
      output push, pop, load, load_val, clear_err,
      input  sp, mem_addr, mem_we, mem_re, depth, full, empty, overflow, underflow
   );

   modport slave (
      input  push, pop, load, load_val, clear_err,
      output sp, mem_addr, mem_we, mem_re, depth, full, empty, overflow, underflow
   );
endinterface

// File: rtl/stack_pointer.sv
// 16-bit descending stack pointer with registered memory address/strobes.
// Define SP_BOUNDS_CHECK_EN to reject push-while-full / pop-while-empty with sticky flags.
module stack_pointer #(
   parameter logic [15:0] SP_INIT  = 16'hFFFF,
   parameter logic [15:0] SP_LIMIT = 16'hF000
) (
   input logic             clk,
   input logic             reset,
   stack_pointer_if.slave  bus
);

   localparam int unsigned W = 16;

`ifdef SP_BOUNDS_CHECK_EN
   localparam bit BoundsEn = 1'b1;
`else
   localparam bit BoundsEn = 1'b0;
`endif

   logic [W-1:0] sp_q, sp_d;
   logic [W-1:0] mem_addr_q, mem_addr_d;
   logic         mem_we_q, mem_we_d;
   logic         mem_re_q, mem_re_d;
   logic         full_c, empty_c;
   logic         push_rej_c, pop_rej_c;

   assign full_c  = (sp_q == SP_LIMIT);
   assign empty_c = (sp_q == SP_INIT);

   // Rejection only exists when bounds checking is built in.
   assign push_rej_c = BoundsEn && full_c;
   assign pop_rej_c  = BoundsEn && empty_c;

   // Priority: load > push+pop no-op > push > pop > idle.
   always_comb begin
      sp_d       = sp_q;
      mem_addr_d = mem_addr_q;
      mem_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      if (bus.load) begin
         sp_d = bus.load_val;
      end else if (bus.push && bus.pop) begin
         sp_d = sp_q;
      end else if (bus.push) begin
         if (!push_rej_c) begin
            sp_d       = W'(sp_q - W'(1));
            mem_addr_d = W'(sp_q - W'(1));
            mem_we_d   = 1'b1;
         end
      end else if (bus.pop) begin
         if (!pop_rej_c) begin
            sp_d       = W'(sp_q + W'(1));
            mem_addr_d = sp_q;
            mem_re_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q       <= SP_INIT;
         mem_addr_q <= '0;
         mem_we_q   <= 1'b0;
         mem_re_q   <= 1'b0;
      end else begin
         sp_q       <= sp_d;
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         mem_re_q   <= mem_re_d;
      end
   end

`ifdef SP_BOUNDS_CHECK_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;
   logic push_err_c, pop_err_c;

   // An error in the same cycle as clear_err wins over the clear.
   assign push_err_c = !bus.load && bus.push && !bus.pop && push_rej_c;
   assign pop_err_c  = !bus.load && bus.pop && !bus.push && pop_rej_c;

   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.clear_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (push_err_c) overflow_d  = 1'b1;
      if (pop_err_c)  underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

   assign bus.sp       = sp_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_re   = mem_re_q;
   assign bus.depth    = W'(SP_INIT - sp_q);
   assign bus.full     = full_c;
   assign bus.empty    = empty_c;

endmodule

// File: doc/stack_pointer.md
# stack_pointer

- 16-bit stack pointer register for the CPU datapath: the decrementing counterpart of the PC incrementer.
- Push pre-decrements and pop post-increments.
- Each accepted operation produces one registered memory-address/strobe cycle for the data memory port.
- Optional bounds checking rejects operations that would leave the stack window and records sticky error flags.

## Interface
Parameters:
- SP_INIT, 16'hFFFF, reset/empty value of the pointer (top of stack, exclusive)
- SP_LIMIT, 16'hF000, lowest legal pointer value (stack full when sp == SP_LIMIT)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- push  input  1  request push this cycle
- pop  input  1  request pop this cycle
- load  input  1  overwrite pointer with load_val
- load_val  input  16  new pointer value
- clear_err  input  1  clear sticky error flags
- sp  output  16  current pointer (registered)
- mem_addr  output  16  memory address for the accepted operation (registered)
- mem_we  output  1  one-cycle write strobe (accepted push)
- mem_re  output  1  one-cycle read strobe (accepted pop)
- depth  output  16  SP_INIT - sp, modulo 2^16 (combinational from sp)
- full  output  1  sp == SP_LIMIT (combinational from sp)
- empty  output  1  sp == SP_INIT (combinational from sp)
- overflow  output  1  sticky: push rejected while full
- underflow  output  1  sticky: pop rejected while empty

## Operation
- Reset: sp=SP_INIT, mem_addr=0, mem_we=0, mem_re=0, overflow=0, underflow=0. Reset overrides all requests, including mid-sequence.
- Each cycle, exactly one action is selected, in priority order:
  - load: sp<=load_val; no strobes; flags unchanged.
  - push and pop both high: no-op; sp unchanged, no strobes, no flag change.
  - push: mem_addr<=sp-1, mem_we<=1, sp<=sp-1.
  - pop: mem_addr<=sp, mem_re<=1, sp<=sp+1.
  - none: mem_we<=0, mem_re<=0, mem_addr holds.
- Strobes are single-cycle: they deassert on the next edge unless a new operation is accepted. Back-to-back operations give consecutive strobe cycles.
- Arithmetic is 16-bit unsigned and wraps modulo 2^16. No carry is kept.
- clear_err clears both flags in the same cycle. A new error detected in the same cycle as clear_err wins, and its flag is set.
- Flags only change on rejected operations or on clear_err/reset.

## Timing
- Requests are sampled on the rising edge of clk.
- sp, mem_addr and strobes are valid in the cycle after the request (latency 1).
- full, empty and depth follow sp with no extra delay.
- Throughput: one operation per cycle.
- Push writes at the new sp. Pop reads at the old sp. A push followed immediately by a pop therefore targets the same address.

## Configuration
- SP_BOUNDS_CHECK_EN defined:
  - A push while full is rejected: no sp change, no mem_we, overflow<=1.
  - A pop while empty is rejected: no sp change, no mem_re, underflow<=1.
  - load is never checked.
- SP_BOUNDS_CHECK_EN undefined:
  - No rejection. Pointer wraps freely; a pop at 16'hFFFF gives sp=16'h0000.
  - overflow and underflow are tied to 0. full and empty are still reported.

## Test plan
- Reset, then 3 pushes on consecutive cycles:
  - mem_addr=FFFE, FFFD, FFFC with mem_we high on three consecutive cycles.
  - Final sp=FFFC, depth=3, empty=0.
- Then 3 pops:
  - mem_addr=FFFC, FFFD, FFFE with mem_re high on three cycles.
  - sp=FFFF, empty=1, no error flags.
- Pop at empty with the macro defined: sp stays FFFF, mem_re=0, underflow=1. clear_err -> underflow=0.
- Same pop with the macro undefined: sp=0000, mem_addr=FFFF, mem_re=1, underflow=0.
- load_val=F001 then 2 pushes with the macro defined:
  - First push: mem_addr=F000, sp=F000, full=1.
  - Second push: rejected, overflow=1, sp=F000.
- push=pop=1 and push=load=1 cases:
  - push+pop: sp unchanged, no strobes.
  - push+load with load_val=8000: sp=8000, no strobe.
- Reset asserted in the same cycle as a push at sp=FFF0: next cycle sp=FFFF, mem_we=0, mem_addr=0.
